// File: rtl/softmax_sum_pkg.sv
// -----------------------------------------------------------------------------
// softmax_sum_pkg
// Shared types and constants for the softmax denominator sum scheduler.
//   - mode_e   : segment mode of a beat (4x16, 2x32, 1x64, multi-beat row)
//   - state_e  : scheduler state (IDLE, RUN, DRAIN)
//   - CTL_*    : bit positions inside the 4-bit tree length-mode control word
//   - FX_W     : width of one FX16 lane / sum
// -----------------------------------------------------------------------------
package softmax_sum_pkg;

  localparam int FX_W     = 16;
  localparam int CTL_LAST = 3;
  localparam int CTL_CONT = 2;

  typedef enum logic [1:0] {
    M16  = 2'd0,
    M32  = 2'd1,
    M64  = 2'd2,
    MROW = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/sum_sched_acc.sv
// -----------------------------------------------------------------------------
// sum_sched_acc
// Running accumulator for multi-beat (mode 3) rows of the softmax denominator.
// The row sum is combinational: (cont ? acc : 0) + sum64. On an enabled beat
// the accumulator takes the row sum, or clears if the beat closes the row.
//
// Ports:
//   i_clk, i_rst   clock, synchronous active-low reset
//   i_clr          clear the accumulator (scheduler returning to IDLE)
//   i_en           a mode-3 beat is being consumed from the tree this cycle
//   i_cont         beat continues an open row (use the accumulator)
//   i_last         beat closes the row
//   i_sum64        64-lane tree sum of the beat
//   o_row_sum      partial / final row sum including this beat
//
// Build option: SOFTMAX_SUM_SAT_EN selects a saturating add
// (clamps to 16'h7FFF / 16'h8000) instead of wrap-around.
// -----------------------------------------------------------------------------
module sum_sched_acc
  import softmax_sum_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_clr,
  input  logic            i_en,
  input  logic            i_cont,
  input  logic            i_last,
  input  logic [FX_W-1:0] i_sum64,
  output logic [FX_W-1:0] o_row_sum
);

  logic [FX_W-1:0] acc_q, acc_d;
  logic [FX_W-1:0] base;

  // A new row starts from zero rather than whatever the previous row left.
  assign base = i_cont ? acc_q : '0;

`ifdef SOFTMAX_SUM_SAT_EN
  // Sign-extend by one bit; the two top bits disagree exactly on overflow,
  // and the top bit then tells which rail to clamp to.
  logic [FX_W:0] wide_sum;
  assign wide_sum = {base[FX_W-1], base} + {i_sum64[FX_W-1], i_sum64};

  always_comb begin
    o_row_sum = wide_sum[FX_W-1:0];
    if (wide_sum[FX_W] != wide_sum[FX_W-1]) begin
      o_row_sum = wide_sum[FX_W] ? {1'b1, {(FX_W-1){1'b0}}}
                                 : {1'b0, {(FX_W-1){1'b1}}};
    end
  end
`else
  assign o_row_sum = base + i_sum64;
`endif

  // Accumulator next-state: clear on request, otherwise follow enabled beats.
  always_comb begin
    acc_d = acc_q;
    if (i_clr) begin
      acc_d = '0;
    end else if (i_en) begin
      acc_d = i_last ? '0 : o_row_sum;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/softmax_sum_sched.sv
// -----------------------------------------------------------------------------
// softmax_sum_sched
// Sequencing controller for the 64-lane, 12-cycle FX16 adder tree of the
// softmax denominator. Input beats enter the tree over valid/ready; per-beat
// control travels through the tree's length-mode bypass, so the output side
// decodes it as the sums emerge, selects 16/32/64-lane sums, accumulates
// multi-beat rows and presents results in a valid/ready output register.
// The whole tree stalls under output backpressure, so nothing is dropped.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-low reset
//   i_flush                 stop accepting, drain in-flight beats, go IDLE
//   i_in_valid/o_in_ready   input beat handshake
//   i_in_data               64 x FX16 lanes
//   i_in_mode, i_in_last    segment mode, last beat of a mode-3 row
//   o_tree_rst/en/valid     tree reset (active-high), clock enable, beat valid
//   o_tree_length_mode      {last, cont, mode[1:0]}
//   o_tree_in1              tree data input (= i_in_data)
//   i_tree_sum64/32/16      tree segment sums
//   i_tree_valid_byp        valid from tree bypass
//   i_tree_mode_byp         control word from tree bypass
//   o_out_valid/i_out_ready result handshake
//   o_out_sum, o_out_cnt    up to 4 FX16 sums, number of valid lanes
//   o_busy                  not IDLE
//   o_err                   sticky: a mode-3 row overran MAX_BEATS
//
// Build option: SOFTMAX_SUM_SAT_EN (saturating mode-3 accumulation, see
// sum_sched_acc).
// -----------------------------------------------------------------------------
module softmax_sum_sched
  import softmax_sum_pkg::*;
#(
  parameter int TREE_LAT  = 12,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_flush,
  input  logic          i_in_valid,
  output logic          o_in_ready,
  input  logic [1023:0] i_in_data,
  input  logic [1:0]    i_in_mode,
  input  logic          i_in_last,
  output logic          o_tree_rst,
  output logic          o_tree_en,
  output logic          o_tree_valid,
  output logic [3:0]    o_tree_length_mode,
  output logic [1023:0] o_tree_in1,
  input  logic [15:0]   i_tree_sum64,
  input  logic [31:0]   i_tree_sum32,
  input  logic [63:0]   i_tree_sum16,
  input  logic          i_tree_valid_byp,
  input  logic [3:0]    i_tree_mode_byp,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [63:0]   o_out_sum,
  output logic [2:0]    o_out_cnt,
  output logic          o_busy,
  output logic          o_err
);

  localparam int BEAT_W = $clog2(MAX_BEATS);

  // The in-flight counter has to be able to hold a completely full tree.
  if (CNT_W < $clog2(TREE_LAT + 1)) begin : g_cnt_w_check
    $error("softmax_sum_sched: CNT_W too narrow for TREE_LAT");
  end

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  inflight_q, inflight_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              err_q, err_d;
  logic              out_valid_q, out_valid_d;
  logic [63:0]       out_sum_q, out_sum_d;
  logic [2:0]        out_cnt_q, out_cnt_d;

  logic        advance, accept, consume;
  logic        in_is_row, row_full, ctl_last, ctl_cont, forced_last;
  logic [3:0]  ctl;
  mode_e       byp_mode;
  logic        byp_cont, byp_last;
  logic        acc_en, acc_clr;
  logic [FX_W-1:0] row_sum;
  logic        produced;
  logic [63:0] res_sum;
  logic [2:0]  res_cnt;

  // Handshake and tree drive. Everything input-facing is gated by i_rst so
  // the block is silent the moment reset is asserted.
  assign advance      = !out_valid_q || i_out_ready;
  assign o_tree_en    = advance && i_rst;
  assign o_in_ready   = advance && (state_q != DRAIN) && i_rst;
  assign accept       = i_in_valid && o_in_ready;
  assign o_tree_valid = accept;
  assign o_tree_rst   = !i_rst;
  assign o_tree_in1   = i_in_data;

  // Per-beat control word. The MAX_BEATS-th beat of a row is always closed,
  // and an overrun (closed without i_in_last) is flagged.
  assign in_is_row   = (mode_e'(i_in_mode) == MROW);
  assign row_full    = (beat_q == BEAT_W'(MAX_BEATS - 1));
  assign ctl_last    = !in_is_row || i_in_last || row_full;
  assign ctl_cont    = in_is_row && (beat_q != '0);
  assign forced_last = in_is_row && row_full && !i_in_last;

  always_comb begin
    ctl           = {2'b00, i_in_mode};
    ctl[CTL_CONT] = ctl_cont;
    ctl[CTL_LAST] = ctl_last;
  end
  assign o_tree_length_mode = ctl;

  // Output side: the bypass control word arrives aligned with the sums.
  assign consume  = advance && i_tree_valid_byp;
  assign byp_mode = mode_e'(i_tree_mode_byp[1:0]);
  assign byp_cont = i_tree_mode_byp[CTL_CONT];
  assign byp_last = i_tree_mode_byp[CTL_LAST];
  assign acc_en   = consume && (byp_mode == MROW);

  sum_sched_acc u_acc (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (acc_clr),
    .i_en      (acc_en),
    .i_cont    (byp_cont),
    .i_last    (byp_last),
    .i_sum64   (i_tree_sum64),
    .o_row_sum (row_sum)
  );

  // Result selection for the beat leaving the tree this cycle.
  always_comb begin
    produced = 1'b0;
    res_sum  = '0;
    res_cnt  = '0;
    if (consume) begin
      unique case (byp_mode)
        M16: begin
          produced = 1'b1;
          res_sum  = i_tree_sum16;
          res_cnt  = 3'd4;
        end
        M32: begin
          produced = 1'b1;
          res_sum  = {32'd0, i_tree_sum32};
          res_cnt  = 3'd2;
        end
        M64: begin
          produced = 1'b1;
          res_sum  = {48'd0, i_tree_sum64};
          res_cnt  = 3'd1;
        end
        MROW: begin
          if (byp_last) begin
            produced = 1'b1;
            res_sum  = {{(64-FX_W){1'b0}}, row_sum};
            res_cnt  = 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Scheduler FSM next state. A flush in IDLE has nothing to drain.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (i_flush) state_d = DRAIN;
      DRAIN:   if ((inflight_q == '0) && !out_valid_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign acc_clr = (state_q == DRAIN) && (state_d == IDLE);

  // Counters, error flag and output register next state. The output register
  // only moves on advance, which holds a stalled result stable.
  always_comb begin
    beat_d      = beat_q;
    inflight_d  = inflight_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_cnt_d   = out_cnt_q;

    if (accept) begin
      if (ctl_last) begin
        beat_d = '0;
      end else begin
        beat_d = beat_q + BEAT_W'(1);
      end
      if (forced_last) begin
        err_d = 1'b1;
      end
    end

    unique case ({accept, consume})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase

    if (advance) begin
      out_valid_d = produced;
      if (produced) begin
        out_sum_d = res_sum;
        out_cnt_d = res_cnt;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      inflight_q  <= '0;
      beat_q      <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      inflight_q  <= inflight_d;
      beat_q      <= beat_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cnt_q   <= out_cnt_d;
    end
  end

  assign o_out_valid = out_valid_q;
  assign o_out_sum   = out_sum_q;
  assign o_out_cnt   = out_cnt_q;
  assign o_busy      = (state_q != IDLE);
  assign o_err       = err_q;

endmodule

// File: tb/tb_softmax_sum_sched.sv
// -----------------------------------------------------------------------------
// tb_softmax_sum_sched
// Self-checking bench for softmax_sum_sched. A behavioural 12-stage adder
// tree closes the loop around the scheduler. Accepted beats feed a row-level
// reference model that predicts every result; results leaving the output
// handshake are collected and compared inside each scenario task.
// -----------------------------------------------------------------------------
module tb_softmax_sum_sched;

  localparam int TL = 12;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_flush = 1'b0;
  logic          i_in_valid = 1'b0;
  logic          o_in_ready;
  logic [1023:0] i_in_data = '0;
  logic [1:0]    i_in_mode = '0;
  logic          i_in_last = 1'b0;
  logic          o_tree_rst, o_tree_en, o_tree_valid;
  logic [3:0]    o_tree_length_mode;
  logic [1023:0] o_tree_in1;
  logic [15:0]   i_tree_sum64;
  logic [31:0]   i_tree_sum32;
  logic [63:0]   i_tree_sum16;
  logic          i_tree_valid_byp;
  logic [3:0]    i_tree_mode_byp;
  logic          o_out_valid;
  logic          i_out_ready = 1'b1;
  logic [63:0]   o_out_sum;
  logic [2:0]    o_out_cnt;
  logic          o_busy, o_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  softmax_sum_sched dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_flush            (i_flush),
    .i_in_valid         (i_in_valid),
    .o_in_ready         (o_in_ready),
    .i_in_data          (i_in_data),
    .i_in_mode          (i_in_mode),
    .i_in_last          (i_in_last),
    .o_tree_rst         (o_tree_rst),
    .o_tree_en          (o_tree_en),
    .o_tree_valid       (o_tree_valid),
    .o_tree_length_mode (o_tree_length_mode),
    .o_tree_in1         (o_tree_in1),
    .i_tree_sum64       (i_tree_sum64),
    .i_tree_sum32       (i_tree_sum32),
    .i_tree_sum16       (i_tree_sum16),
    .i_tree_valid_byp   (i_tree_valid_byp),
    .i_tree_mode_byp    (i_tree_mode_byp),
    .o_out_valid        (o_out_valid),
    .i_out_ready        (i_out_ready),
    .o_out_sum          (o_out_sum),
    .o_out_cnt          (o_out_cnt),
    .o_busy             (o_busy),
    .o_err              (o_err)
  );

  // Free-running clock and cycle counter used for latency measurements.
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Wrapping 16-bit sum of n consecutive lanes starting at lane lo.
  function automatic logic [15:0] laneSum(input logic [1023:0] d, input int lo, input int n);
    logic [15:0] s;
    s = '0;
    for (int i = lo; i < lo + n; i++) s += d[16*i +: 16];
    return s;
  endfunction

  // Behavioural adder tree: a TL-deep pipeline that stalls as a whole.
  logic        tv [TL];
  logic [3:0]  tm [TL];
  logic [15:0] t64[TL];
  logic [31:0] t32[TL];
  logic [63:0] t16[TL];

  always @(posedge i_clk) begin
    if (o_tree_rst) begin
      for (int k = 0; k < TL; k++) begin
        tv[k] <= 1'b0; tm[k] <= '0; t64[k] <= '0; t32[k] <= '0; t16[k] <= '0;
      end
    end else if (o_tree_en) begin
      tv[0]  <= o_tree_valid;
      tm[0]  <= o_tree_length_mode;
      t64[0] <= laneSum(o_tree_in1, 0, 64);
      t32[0] <= {laneSum(o_tree_in1, 32, 32), laneSum(o_tree_in1, 0, 32)};
      t16[0] <= {laneSum(o_tree_in1, 48, 16), laneSum(o_tree_in1, 32, 16),
                 laneSum(o_tree_in1, 16, 16), laneSum(o_tree_in1, 0, 16)};
      for (int k = 1; k < TL; k++) begin
        tv[k] <= tv[k-1]; tm[k] <= tm[k-1];
        t64[k] <= t64[k-1]; t32[k] <= t32[k-1]; t16[k] <= t16[k-1];
      end
    end
  end

  assign i_tree_valid_byp = tv[TL-1];
  assign i_tree_mode_byp  = tm[TL-1];
  assign i_tree_sum64     = t64[TL-1];
  assign i_tree_sum32     = t32[TL-1];
  assign i_tree_sum16     = t16[TL-1];

  // Row-level reference model.
  typedef struct {
    logic [63:0] sum;
    logic [2:0]  cnt;
    int          cyc;
  } res_t;

  res_t        expQ[$];
  res_t        obsQ[$];
  int          rowCnt = 0;
  logic [15:0] rowAcc = '0;
  logic        expErr = 1'b0;

  function automatic logic [15:0] fxAdd(input logic [15:0] a, input logic [15:0] b);
`ifdef SOFTMAX_SUM_SAT_EN
    int s;
    s = int'($signed(a)) + int'($signed(b));
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return s[15:0];
`else
    return a + b;
`endif
  endfunction

  function automatic void modelAccept(input logic [1023:0] d, input logic [1:0] m, input logic l);
    res_t r;
    r.cyc = cyc;
    if (m == 2'd3) begin
      rowAcc = fxAdd(rowAcc, laneSum(d, 0, 64));
      rowCnt++;
      if (l || rowCnt == 16) begin
        if (!l) expErr = 1'b1;
        r.sum = {48'd0, rowAcc};
        r.cnt = 3'd1;
        expQ.push_back(r);
        rowCnt = 0;
        rowAcc = '0;
      end
    end else begin
      rowCnt = 0;
      rowAcc = '0;
      if (m == 2'd0) begin
        r.sum = {laneSum(d, 48, 16), laneSum(d, 32, 16), laneSum(d, 16, 16), laneSum(d, 0, 16)};
        r.cnt = 3'd4;
      end else if (m == 2'd1) begin
        r.sum = {32'd0, laneSum(d, 32, 32), laneSum(d, 0, 32)};
        r.cnt = 3'd2;
      end else begin
        r.sum = {48'd0, laneSum(d, 0, 64)};
        r.cnt = 3'd1;
      end
      expQ.push_back(r);
    end
  endfunction

  function automatic void clearModel();
    expQ.delete();
    obsQ.delete();
    rowCnt = 0;
    rowAcc = '0;
    expErr = 1'b0;
  endfunction

  // Monitor: record accepted beats into the model and completed results.
  always @(negedge i_clk) begin
    if (i_rst) begin
      if (o_tree_valid) modelAccept(i_in_data, i_in_mode, i_in_last);
      if (o_out_valid && i_out_ready) begin
        res_t o;
        o.sum = o_out_sum;
        o.cnt = o_out_cnt;
        o.cyc = cyc;
        obsQ.push_back(o);
      end
    end
  end

  function automatic logic [1023:0] fillLanes(input logic [15:0] v);
    logic [1023:0] d;
    for (int i = 0; i < 64; i++) d[16*i +: 16] = v;
    return d;
  endfunction

  function automatic logic [1023:0] randLanes();
    logic [1023:0] d;
    for (int i = 0; i < 64; i++) d[16*i +: 16] = 16'($urandom);
    return d;
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Present one beat and hold it until the DUT accepts it (bounded).
  task automatic applyStimulus(input logic [1023:0] d, input logic [1:0] m, input logic l);
    int w;
    w = 0;
    i_in_valid = 1'b1;
    i_in_data  = d;
    i_in_mode  = m;
    i_in_last  = l;
    @(negedge i_clk);
    while (!o_in_ready && w < 200) begin
      @(negedge i_clk);
      w++;
    end
    checks++;
    if (!o_in_ready) begin
      errors++;
      $display("[TB] FAIL accept_timeout: o_in_ready=%0b required 1", o_in_ready);
    end
    tick();
    i_in_valid = 1'b0;
  endtask

  // Wait until every predicted result has appeared, then let the pipe settle.
  task automatic waitDrain(output bit ok);
    int w;
    w = 0;
    while (obsQ.size() < expQ.size() && w < 400) begin
      tick();
      w++;
    end
    ok = (obsQ.size() >= expQ.size());
    repeat (16) tick();
  endtask

  task automatic test_reset();
    i_rst = 1'b0;
    i_in_valid = 1'b1;
    i_in_data  = fillLanes(16'h0001);
    repeat (3) tick();
    @(negedge i_clk);
    checks++;
    if ({o_out_valid, o_out_cnt, o_busy, o_in_ready, o_tree_valid, o_tree_en, o_tree_rst, o_err} !== 10'b0000000010) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got v=%0b cnt=%0d busy=%0b rdy=%0b tv=%0b en=%0b trst=%0b err=%0b required 0,0,0,0,0,0,1,0",
               o_out_valid, o_out_cnt, o_busy, o_in_ready, o_tree_valid, o_tree_en, o_tree_rst, o_err);
    end
    checks++;
    if (o_out_sum !== 64'd0) begin
      errors++;
      $display("[TB] FAIL reset_sum: got %h required 0", o_out_sum);
    end
    i_in_valid = 1'b0;
    clearModel();
    tick();
    i_rst = 1'b1;
    tick();
    @(negedge i_clk);
    checks++;
    if ({o_in_ready, o_tree_en, o_tree_rst, o_busy} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL reset_release: got rdy=%0b en=%0b trst=%0b busy=%0b required 1,1,0,0",
               o_in_ready, o_tree_en, o_tree_rst, o_busy);
    end
    tick();
  endtask

  task automatic test_mode0();
    bit ok;
    res_t o, e;
    applyStimulus(fillLanes(16'h0001), 2'd0, 1'b1);
    waitDrain(ok);
    checks++;
    if (!ok || obsQ.size() != 1 || expQ.size() != 1) begin
      errors++;
      $display("[TB] FAIL mode0_count: got %0d results required 1", obsQ.size());
    end
    if (obsQ.size() > 0 && expQ.size() > 0) begin
      o = obsQ.pop_front();
      e = expQ.pop_front();
      checks++;
      if (o.sum !== 64'h0010_0010_0010_0010 || o.cnt !== 3'd4) begin
        errors++;
        $display("[TB] FAIL mode0_sum: got %h/%0d required 0010001000100010/4", o.sum, o.cnt);
      end
      checks++;
      if (o.cyc - e.cyc != 13) begin
        errors++;
        $display("[TB] FAIL mode0_latency: got %0d cycles required 13", o.cyc - e.cyc);
      end
    end
    clearModel();
  endtask

  task automatic test_back_to_back();
    bit ok;
    res_t o0, o1;
    applyStimulus(fillLanes(16'h0001), 2'd1, 1'b1);
    applyStimulus(fillLanes(16'h0001), 2'd2, 1'b1);
    waitDrain(ok);
    checks++;
    if (!ok || obsQ.size() != 2) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d results required 2", obsQ.size());
    end
    if (obsQ.size() >= 2) begin
      o0 = obsQ.pop_front();
      o1 = obsQ.pop_front();
      checks++;
      if (o0.sum !== 64'h0000_0000_0020_0020 || o0.cnt !== 3'd2) begin
        errors++;
        $display("[TB] FAIL b2b_mode1: got %h/%0d required 0000000000200020/2", o0.sum, o0.cnt);
      end
      checks++;
      if (o1.sum !== 64'h0040 || o1.cnt !== 3'd1) begin
        errors++;
        $display("[TB] FAIL b2b_mode2: got %h/%0d required 0000000000000040/1", o1.sum, o1.cnt);
      end
      checks++;
      if (o1.cyc - o0.cyc != 1) begin
        errors++;
        $display("[TB] FAIL b2b_spacing: got %0d cycles required 1", o1.cyc - o0.cyc);
      end
    end
    clearModel();
  endtask

  task automatic test_row();
    bit ok;
    res_t o, e;
    for (int j = 0; j < 3; j++) applyStimulus(fillLanes(16'h0001), 2'd3, j == 2);
    waitDrain(ok);
    checks++;
    if (!ok || obsQ.size() != 1) begin
      errors++;
      $display("[TB] FAIL row3_count: got %0d results required 1", obsQ.size());
    end
    if (obsQ.size() > 0) begin
      o = obsQ[0];
      checks++;
      if (o.sum !== 64'h00C0 || o.cnt !== 3'd1) begin
        errors++;
        $display("[TB] FAIL row3_sum: got %h/%0d required 00000000000000c0/1", o.sum, o.cnt);
      end
    end
    clearModel();
    for (int r = 0; r < 5; r++) begin
      int len;
      len = $urandom_range(1, 7);
      for (int j = 0; j < len; j++) applyStimulus(randLanes(), 2'd3, j == len - 1);
    end
    waitDrain(ok);
    checks++;
    if (!ok || obsQ.size() != expQ.size()) begin
      errors++;
      $display("[TB] FAIL row_rand_count: got %0d results required %0d", obsQ.size(), expQ.size());
    end
    while (obsQ.size() > 0 && expQ.size() > 0) begin
      o = obsQ.pop_front();
      e = expQ.pop_front();
      checks++;
      if (o.sum !== e.sum || o.cnt !== e.cnt) begin
        errors++;
        $display("[TB] FAIL row_rand_sum: got %h/%0d required %h/%0d", o.sum, o.cnt, e.sum, e.cnt);
      end
    end
    clearModel();
  endtask

  task automatic test_backpressure();
    bit ok;
    int w;
    logic [63:0] held;
    res_t o, e;
    for (int j = 0; j < 4; j++) applyStimulus(randLanes(), 2'd0, 1'b1);
    w = 0;
    @(negedge i_clk);
    while (!o_out_valid && w < 40) begin
      @(negedge i_clk);
      w++;
    end
    tick();
    i_out_ready = 1'b0;
    held = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      if (i == 0) held = o_out_sum;
      checks++;
      if ({o_in_ready, o_tree_en, o_out_valid} !== 3'b001 || o_out_sum !== held) begin
        errors++;
        $display("[TB] FAIL stall_hold: got rdy=%0b en=%0b v=%0b sum=%h required 0,0,1,%h",
                 o_in_ready, o_tree_en, o_out_valid, o_out_sum, held);
      end
    end
    tick();
    i_out_ready = 1'b1;
    waitDrain(ok);
    checks++;
    if (!ok || obsQ.size() != 4 || expQ.size() != 4) begin
      errors++;
      $display("[TB] FAIL stall_count: got %0d results required 4", obsQ.size());
    end
    while (obsQ.size() > 0 && expQ.size() > 0) begin
      o = obsQ.pop_front();
      e = expQ.pop_front();
      checks++;
      if (o.sum !== e.sum || o.cnt !== e.cnt) begin
        errors++;
        $display("[TB] FAIL stall_order: got %h/%0d required %h/%0d", o.sum, o.cnt, e.sum, e.cnt);
      end
    end
    clearModel();
  endtask

  task automatic test_random();
    bit ok;
    bit stimDone;
    res_t o, e;
    stimDone = 1'b0;
    fork
      begin
        for (int r = 0; r < 30; r++) begin
          logic [1:0] m;
          m = 2'($urandom_range(0, 3));
          if (m == 2'd3) begin
            int len;
            len = $urandom_range(1, 6);
            for (int j = 0; j < len; j++) applyStimulus(randLanes(), 2'd3, j == len - 1);
          end else begin
            applyStimulus(randLanes(), m, 1'b1);
          end
          if ($urandom_range(0, 3) == 0) tick();
        end
        stimDone = 1'b1;
      end
      begin
        while (!stimDone) begin
          tick();
          i_out_ready = ($urandom_range(0, 3) != 0);
        end
        i_out_ready = 1'b1;
      end
    join
    waitDrain(ok);
    checks++;
    if (!ok || obsQ.size() != expQ.size()) begin
      errors++;
      $display("[TB] FAIL random_count: got %0d results required %0d", obsQ.size(), expQ.size());
    end
    while (obsQ.size() > 0 && expQ.size() > 0) begin
      o = obsQ.pop_front();
      e = expQ.pop_front();
      checks++;
      if (o.sum !== e.sum || o.cnt !== e.cnt) begin
        errors++;
        $display("[TB] FAIL random_sum: got %h/%0d required %h/%0d", o.sum, o.cnt, e.sum, e.cnt);
      end
    end
    clearModel();
  endtask

  task automatic test_flush();
    int w;
    res_t o, e;
    for (int j = 0; j < 5; j++) applyStimulus(randLanes(), 2'($urandom_range(0, 2)), 1'b1);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    @(negedge i_clk);
    checks++;
    if ({o_in_ready, o_busy} !== 2'b01) begin
      errors++;
      $display("[TB] FAIL flush_drain: got rdy=%0b busy=%0b required 0,1", o_in_ready, o_busy);
    end
    w = 0;
    while (o_busy && w < 100) begin
      @(negedge i_clk);
      w++;
    end
    checks++;
    if (o_busy !== 1'b0 || obsQ.size() != 5 || expQ.size() != 5) begin
      errors++;
      $display("[TB] FAIL flush_done: got busy=%0b results=%0d required 0, 5", o_busy, obsQ.size());
    end
    while (obsQ.size() > 0 && expQ.size() > 0) begin
      o = obsQ.pop_front();
      e = expQ.pop_front();
      checks++;
      if (o.sum !== e.sum || o.cnt !== e.cnt) begin
        errors++;
        $display("[TB] FAIL flush_sum: got %h/%0d required %h/%0d", o.sum, o.cnt, e.sum, e.cnt);
      end
    end
    checks++;
    if (o_in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_idle_ready: got %0b required 1", o_in_ready);
    end
    clearModel();
    tick();
  endtask

  task automatic test_overrun();
    bit ok;
    res_t o0, o1;
    checks++;
    if (o_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overrun_err_pre: got %0b required 0", o_err);
    end
    for (int j = 0; j < 17; j++) applyStimulus(fillLanes(16'h0001), 2'd3, 1'b0);
    applyStimulus(fillLanes(16'h0001), 2'd3, 1'b1);
    waitDrain(ok);
    checks++;
    if (!ok || obsQ.size() != 2) begin
      errors++;
      $display("[TB] FAIL overrun_count: got %0d results required 2", obsQ.size());
    end
    if (obsQ.size() >= 2) begin
      o0 = obsQ.pop_front();
      o1 = obsQ.pop_front();
      checks++;
      if (o0.sum !== 64'h0400 || o0.cnt !== 3'd1) begin
        errors++;
        $display("[TB] FAIL overrun_forced: got %h/%0d required 0000000000000400/1", o0.sum, o0.cnt);
      end
      checks++;
      if (o1.sum !== 64'h0080 || o1.cnt !== 3'd1) begin
        errors++;
        $display("[TB] FAIL overrun_next_row: got %h/%0d required 0000000000000080/1", o1.sum, o1.cnt);
      end
    end
    checks++;
    if (o_err !== expErr || o_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overrun_err: got %0b required 1", o_err);
    end
    clearModel();
  endtask

  task automatic test_reset_mid();
    bit ok;
    res_t o;
    for (int j = 0; j < 16; j++) applyStimulus(randLanes(), 2'd2, 1'b1);
    i_in_valid = 1'b1;
    i_rst = 1'b0;
    @(negedge i_clk);
    checks++;
    if ({o_in_ready, o_tree_valid, o_tree_en, o_tree_rst} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL midrst_comb: got rdy=%0b tv=%0b en=%0b trst=%0b required 0,0,0,1",
               o_in_ready, o_tree_valid, o_tree_en, o_tree_rst);
    end
    tick();
    checks++;
    if ({o_out_valid, o_out_cnt, o_busy, o_err} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL midrst_regs: got v=%0b cnt=%0d busy=%0b err=%0b required 0,0,0,0",
               o_out_valid, o_out_cnt, o_busy, o_err);
    end
    checks++;
    if (o_out_sum !== 64'd0) begin
      errors++;
      $display("[TB] FAIL midrst_sum: got %h required 0", o_out_sum);
    end
    i_in_valid = 1'b0;
    clearModel();
    tick();
    i_rst = 1'b1;
    tick();
    applyStimulus(fillLanes(16'h0003), 2'd2, 1'b1);
    waitDrain(ok);
    checks++;
    if (!ok || obsQ.size() != 1) begin
      errors++;
      $display("[TB] FAIL midrst_after_count: got %0d results required 1", obsQ.size());
    end
    if (obsQ.size() > 0) begin
      o = obsQ.pop_front();
      checks++;
      if (o.sum !== 64'h00C0 || o.cnt !== 3'd1) begin
        errors++;
        $display("[TB] FAIL midrst_after_sum: got %h/%0d required 00000000000000c0/1", o.sum, o.cnt);
      end
    end
    clearModel();
  endtask

  // Scenario sequence.
  initial begin
    $display("[TB] softmax_sum_sched bench starting");
    test_reset();
    test_mode0();
    test_back_to_back();
    test_row();
    test_backpressure();
    test_random();
    test_flush();
    test_overrun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/softmax_sum_sched.md
Name: softmax_sum_sched

Overview:
- Sequencing controller for the 64-lane, 12-cycle FX16 adder tree used in the softmax denominator path.
- Accepts 64-lane exp-value beats over a valid/ready handshake and drives the tree's enable, reset, valid, length-mode and data ports.
- Selects the 16/32/64-segment sums at the tree output, accumulates multi-beat rows (rows longer than 64) and presents the row sums through a valid/ready output register.
- The tree's own length-mode bypass carries per-beat row control, so the block needs no separate delay line.

Parameters:
- TREE_LAT, 12, cycles from tree input to tree sum and bypass outputs (information only; not used in logic).
- MAX_BEATS, 16, maximum beats in one multi-beat row.
- CNT_W, 4, width of the in-flight counter; must hold TREE_LAT.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-low (0 = reset)
- i_flush  in  1  stop accepting input, drain, return to IDLE
- i_in_valid  in  1  input beat valid
- o_in_ready  out  1  input beat ready
- i_in_data  in  1024  64 x FX16 lanes
- i_in_mode  in  2  segment mode: 0 = 4x16, 1 = 2x32, 2 = 1x64, 3 = multi-beat row of 64-lane beats
- i_in_last  in  1  final beat of a mode-3 row
- o_tree_rst  out  1  active-high tree reset, equal to !i_rst
- o_tree_en  out  1  tree clock enable
- o_tree_valid  out  1  beat valid into tree
- o_tree_length_mode  out  4  encoded control; [1:0] mode, [2] continuation, [3] last
- o_tree_in1  out  1024  equal to i_in_data
- i_tree_sum64  in  16  tree 64-lane sum
- i_tree_sum32  in  32  tree 32-lane sums {s1,s0}, already aligned by the tree
- i_tree_sum16  in  64  tree 16-lane sums {s3,s2,s1,s0}, already aligned by the tree
- i_tree_valid_byp  in  1  valid from tree bypass
- i_tree_mode_byp  in  4  encoded control from tree bypass
- o_out_valid  out  1  row-sum result valid
- i_out_ready  in  1  row-sum result ready
- o_out_sum  out  64  up to 4 x FX16 sums; unused lanes are 0
- o_out_cnt  out  3  number of valid lanes: 1, 2 or 4
- o_busy  out  1  state is not IDLE
- o_err  out  1  sticky flag: row overran MAX_BEATS

Behaviour:
- Definition: advance = !o_out_valid || i_out_ready.
- Tree drive: o_tree_en = advance && i_rst. The tree stalls as a whole under backpressure, so nothing is ever dropped.
- Input ready: o_in_ready = advance && state != DRAIN && i_rst.
- Tree valid: o_tree_valid = i_in_valid && o_in_ready. A beat is accepted on that cycle.
- Encoding: [3] is last. It equals i_in_last for mode 3, is forced to 1 on the MAX_BEATS-th beat, and is 1 for modes 0-2. [2] is continuation: 1 when a mode-3 row is already open (beat counter != 0).
- Beat counter: increments on each accepted mode-3 beat. Clears when a beat with [3] = 1 is accepted. A forced last also sets o_err.
- Output side, on a cycle with advance && i_tree_valid_byp, decode i_tree_mode_byp:
  - Mode 0: o_out_sum = i_tree_sum16, cnt 4, result produced.
  - Mode 1: o_out_sum = {32'd0, i_tree_sum32}, cnt 2, result produced.
  - Mode 2: o_out_sum = {48'd0, i_tree_sum64}, cnt 1, result produced.
  - Mode 3, not last: acc <= (cont ? acc : 0) + sum64; no result.
  - Mode 3, last: o_out_sum lane 0 = (cont ? acc : 0) + sum64, cnt 1, result produced; acc <= 0.
- Output register: on advance, o_out_valid <= (result produced). A held result stays stable while i_out_ready = 0.
- Arithmetic: 16-bit two's-complement add, wrap-around.
- In-flight counter: +1 on accept, -1 on output-side consumption of a valid bypass. Simultaneous accept and consume leaves it unchanged.
- States:
  - IDLE to RUN on the first accepted beat.
  - RUN to DRAIN on i_flush.
  - IDLE to DRAIN on i_flush is a no-op; stay in IDLE.
  - DRAIN to IDLE when in-flight = 0 and !o_out_valid.
  - i_flush does not close an open mode-3 row; acc is cleared on entering IDLE.
- Latency: with no stall, a beat accepted at cycle t is visible on o_out at t+13.
- Reset (i_rst = 0), mid-operation included:
  - state IDLE; counters, acc and o_err cleared.
  - o_out_valid = 0, o_out_sum = 0, o_out_cnt = 0, o_busy = 0.
  - o_in_ready = 0, o_tree_valid = 0, o_tree_en = 0, o_tree_rst = 1.
  - The tree's in-flight contents are discarded by its own reset.

Optional Feature:
- Macro: SOFTMAX_SUM_SAT_EN.
- Defined: mode-3 accumulation and the last-beat add saturate to 16'h7FFF / 16'h8000.
- Undefined: wrap-around add.

Decomposition:
- Package softmax_sum_pkg holds:
  - mode enum (M16, M32, M64, MROW)
  - state enum (IDLE, RUN, DRAIN)
  - control field indices (bit 3 = last, bit 2 = continuation)
  - FX16 width constant
- One sub-module, sum_sched_acc: the mode-3 accumulator with optional saturating add.

Test Plan:
- Mode 0, all lanes = 16'h0001, i_out_ready = 1 -> at t+13, o_out_sum = {4{16'h0010}}, cnt 4.
- Mode 1 then mode 2 back-to-back, lanes = 1 -> results {0, 0, 16'h0020, 16'h0020} cnt 2, then 16'h0040 cnt 1, on consecutive cycles.
- Mode-3 row of 3 beats, lanes = 1, i_in_last on the third beat -> a single result 16'h00C0, cnt 1; no outputs for beats 1-2.
- i_out_ready = 0 for 5 cycles with 4 beats in flight -> o_in_ready = 0, o_tree_en = 0, output held; all 4 results delivered in order after release.
- Mode-3 row of 17 beats without last -> forced last on beat 16, o_err = 1, result = 16 x 16'h0040; beat 17 starts a new row.
- i_flush with 5 beats in flight -> o_in_ready = 0, all 5 results delivered, then o_busy = 0. Separately, assert i_rst = 0 mid-stream -> all outputs take their reset values on the next edge.
